// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM state encoding, frame
//               geometry and default clock/baud constants. Intended to be
//               reused by the transmit side of the host link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Data bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // Default system clock and line rate of the NPU host link.
  localparam int C_DEFAULT_CLK_HZ       = 50_000_000;
  localparam int C_DEFAULT_BAUD         = 115_200;
  localparam int C_DEFAULT_CLKS_PER_BIT = C_DEFAULT_CLK_HZ / C_DEFAULT_BAUD;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Integer clocks-per-bit for a given clock and baud rate.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchronizer for a single asynchronous input bit.
//               Both flops reset to RESET_VAL so an idle line does not look
//               like an edge when reset is released.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               d    - asynchronous input
//               q    - synchronized output (two clk cycles latency)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : bit_sync

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module      : uart_rx_deserializer
// Description : Oversampling 8N1 UART receiver. Recovers bytes from an
//               asynchronous serial line and presents each one exactly once
//               on a single-cycle rx_valid strobe. Never stalls.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-low reset
//               rx_serial  - raw UART line, idle high, async to clk
//               rx_data    - last correctly framed byte (held between frames)
//               rx_valid   - one-cycle strobe, rx_data valid in same cycle
//               frame_err  - one-cycle strobe, stop bit sampled low
//               busy       - high from start-edge detection until IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Terminal counts: sampling happens in the cycle the counter hits these.
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);

  // --------------------------------------------------------------------------
  // Input synchronization and start-edge detection
  // --------------------------------------------------------------------------
  logic w_rx_s;
  logic r_rx_prev;
  logic w_start_edge;

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (w_rx_s)
  );

  // Previous synchronized sample resets high so a line that is already low
  // at reset release does not look like a falling edge until it is seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_prev <= w_rx_s;
    end
  end

  assign w_start_edge = r_rx_prev & ~w_rx_s;

  // --------------------------------------------------------------------------
  // FSM, baud counter, bit index and shift register
  // --------------------------------------------------------------------------
  uart_rx_state_t       r_state;
  uart_rx_state_t       w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_valid_next;
  logic                 w_ferr_next;
  logic                 w_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_start_edge) begin
          w_state_next = START;
        end
      end

      // Confirm the start bit at its centre; a high sample means the falling
      // edge was a glitch and the frame is dropped silently.
      START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_next = '0;
          if (!w_rx_s) begin
            w_state_next = DATA;
            w_idx_next   = '0;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      // LSB first; the 3-bit index wraps 7 -> 0 as the FSM leaves DATA.
      DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_next            = '0;
          w_shift_next[r_idx]   = w_rx_s;
          w_idx_next            = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_next = STOP;
          end
        end
      end

      // Leave at the stop-bit centre so a start bit immediately following
      // the stop bit is still caught by the edge detector in IDLE.
      STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_valid_next = 1'b1;
            w_load       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = BREAK;
          end
        end
      end

      // A held-low line (break condition) must go high before any new start
      // edge is accepted.
      BREAK: begin
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= w_valid_next;
      r_frame_err <= w_ferr_next;
      // Registered from the next state so busy tracks the FSM cycle-exact.
      r_busy      <= (w_state_next != IDLE);
      if (w_load) begin
        r_rx_data <= r_shift;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule : uart_rx_deserializer

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Self-checking directed bench for uart_rx_deserializer with
//               CLKS_PER_BIT = 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deserializer;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int passes = 0;

  uart_rx_deserializer #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: records every strobe and the length of each busy run.
  logic [7:0] got_q[$];
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         busy_run  = 0;
  int         busy_len  = 0;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Drive one 10-bit frame; bit widths alternate between w_even and w_odd.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int w_even, input int w_odd);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat ((i % 2 == 0) ? w_even : w_odd) @(negedge clk);
    end
    rx_serial = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_single;
    int base;
    base = got_q.size();
    send_frame(8'hA5, 1'b1, CPB, CPB);
    idle(20);
    checks++; if (got_q.size() !== base + 1) $display("FAIL single_count got %0d want %0d", got_q.size() - base, 1); else passes++;
    if (got_q.size() > base) begin
      checks++; if (got_q[base] !== 8'hA5) $display("FAIL single_data got %h want a5", got_q[base]); else passes++;
    end
    checks++; if (rx_data !== 8'hA5) $display("FAIL single_hold got %h want a5", rx_data); else passes++;
    checks++; if (ferr_cnt !== 0) $display("FAIL single_ferr got %0d want 0", ferr_cnt); else passes++;
    // busy: from the cycle after T0 up to the stop sample = HALF + 9*CPB cycles
    checks++; if (busy_len !== HALF + 9 * CPB) $display("FAIL single_busy_len got %0d want %0d", busy_len, HALF + 9 * CPB); else passes++;
  endtask

  task automatic test_frame_err;
    int base;
    int fbase;
    base  = got_q.size();
    fbase = ferr_cnt;
    send_frame(8'h3C, 1'b0, CPB, CPB);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (ferr_cnt - fbase !== 1) $display("FAIL ferr_count got %0d want 1", ferr_cnt - fbase); else passes++;
    checks++; if (got_q.size() !== base) $display("FAIL ferr_no_valid got %0d want 0", got_q.size() - base); else passes++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL ferr_data_kept got %h want a5", rx_data); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL ferr_break_busy got %b want 1", busy); else passes++;
    idle(10);
    checks++; if (busy !== 1'b0) $display("FAIL ferr_break_exit got %b want 0", busy); else passes++;
    checks++; if (got_q.size() !== base) $display("FAIL ferr_no_false_start got %0d want 0", got_q.size() - base); else passes++;
  endtask

  task automatic test_back_to_back;
    int base;
    int fbase;
    base  = got_q.size();
    fbase = ferr_cnt;
    for (int i = 0; i < 32; i++) begin
      send_frame(8'(i), 1'b1, CPB, CPB);
    end
    idle(20);
    checks++; if (got_q.size() !== base + 32) $display("FAIL b2b_count got %0d want 32", got_q.size() - base); else passes++;
    for (int i = 0; i < 32; i++) begin
      if (base + i < got_q.size()) begin
        checks++; if (got_q[base + i] !== 8'(i)) $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[base + i], 8'(i)); else passes++;
      end
    end
    checks++; if (ferr_cnt !== fbase) $display("FAIL b2b_ferr got %0d want 0", ferr_cnt - fbase); else passes++;
  endtask

  task automatic test_glitch;
    int base;
    base = got_q.size();
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    checks++; if (got_q.size() !== base) $display("FAIL glitch_no_strobe got %0d want 0", got_q.size() - base); else passes++;
    checks++; if (busy_len < 1 || busy_len > HALF + 3) $display("FAIL glitch_busy_len got %0d want 1..%0d", busy_len, HALF + 3); else passes++;
    send_frame(8'h3C, 1'b1, CPB, CPB);
    idle(20);
    checks++; if (got_q.size() !== base + 1) $display("FAIL glitch_follow_count got %0d want 1", got_q.size() - base); else passes++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL glitch_follow_data got %h want 3c", rx_data); else passes++;
  endtask

  task automatic test_reset_midframe;
    int base;
    int fbase;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;                 // bits 0..3 of 0xFF
    repeat (4 * CPB + HALF) @(negedge clk);  // now inside data bit 4
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL midrst_rx_data got %h want 00", rx_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passes++;
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL midrst_strobes got %b%b want 00", rx_valid, frame_err); else passes++;
    rst = 1'b1;
    base  = got_q.size();
    fbase = ferr_cnt;
    idle(200);
    checks++; if (got_q.size() !== base || ferr_cnt !== fbase) $display("FAIL midrst_aborted got %0d/%0d want 0/0", got_q.size() - base, ferr_cnt - fbase); else passes++;
    send_frame(8'h81, 1'b1, CPB, CPB);
    idle(20);
    checks++; if (got_q.size() !== base + 1) $display("FAIL midrst_follow_count got %0d want 1", got_q.size() - base); else passes++;
    checks++; if (rx_data !== 8'h81) $display("FAIL midrst_follow_data got %h want 81", rx_data); else passes++;
  endtask

  task automatic test_skew;
    int base;
    base = got_q.size();
    send_frame(8'h55, 1'b1, 15, 16);  // 15.5 cycles/bit average
    idle(20);
    checks++; if (got_q.size() !== base + 1 || rx_data !== 8'h55) $display("FAIL skew_fast got %h n=%0d want 55 n=1", rx_data, got_q.size() - base); else passes++;
    send_frame(8'hAA, 1'b1, CPB, CPB);  // distinct value between skew runs
    idle(20);
    base = got_q.size();
    send_frame(8'h55, 1'b1, 17, 16);  // 16.5 cycles/bit average
    idle(20);
    checks++; if (got_q.size() !== base + 1 || rx_data !== 8'h55) $display("FAIL skew_slow got %h n=%0d want 55 n=1", rx_data, got_q.size() - base); else passes++;
  endtask

  task automatic test_exclusive;
    checks++; if (both_cnt !== 0) $display("FAIL strobe_exclusive got %0d want 0", both_cnt); else passes++;
  endtask

  initial begin
    rst = 1'b0;
    rx_serial = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_midframe();
    test_skew();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_uart_rx_deserializer

`default_nettype wire
